// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, datapath
// select codes and the state enumeration.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Opcode/handshake inputs and datapath strobes between the control FSM
// (master) and the multi-cycle datapath (slave).
interface multicycle_control_if #(
  parameter int unsigned OPW    = 6,
  parameter int unsigned ALUOPW = 2
);
  logic [OPW-1:0]    opcode;
  logic              mem_ready;
  logic              pc_write;
  logic              pc_write_cond;
  logic              i_or_d;
  logic              mem_read;
  logic              mem_write;
  logic              ir_write;
  logic              mem_to_reg;
  logic              reg_dst;
  logic              reg_write;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic [ALUOPW-1:0] alu_op;
  logic [1:0]        pc_source;
  logic [3:0]        state;
  logic              instr_done;
  logic              illegal_op;
  logic              mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_done, illegal_op, mem_timeout
  );
endinterface

// File: rtl/multicycle_control_mem_wait_watchdog.sv
// Counts not-ready cycles in a memory wait state and flags the cycle in which
// the wait limit is reached without mem_ready.
module mem_wait_watchdog #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNTW    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  input  logic i_ready,
  output logic o_timeout
);
  localparam logic [CNTW-1:0] LIMIT = CNTW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  logic [CNTW-1:0] r_cnt;
  logic            w_hit;

  // r_cnt holds the not-ready cycles already spent, so the current cycle is r_cnt+1
  assign w_hit     = (TIMEOUT != 0) && (r_cnt >= LIMIT);
  assign o_timeout = i_wait && !i_ready && w_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_wait || i_ready || o_timeout) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes per-state datapath strobes, with a watchdog on memory waits.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned OPW         = 6,
  parameter int unsigned ALUOPW      = 2,
  parameter int unsigned MEM_WAIT_EN = 1,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned CNTW        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  state_t            r_state, w_next;
  logic [OPW-1:0]    r_op;
  logic              w_ready, w_wait, w_timeout;
  logic              w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
  logic              w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic              w_instr_done, w_illegal_op;
  logic [1:0]        w_alu_src_b, w_pc_source;
  logic [ALUOPW-1:0] w_alu_op;

  assign w_ready = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;
  assign w_wait  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  mem_wait_watchdog #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_wait    (w_wait),
    .i_ready   (w_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= bus.opcode;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_B;
    w_alu_op        = ALUOPW'(ALU_ADD);
    w_pc_source     = PCSRC_ALU;
    w_instr_done    = 1'b0;
    w_illegal_op    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = w_ready;
        w_pc_write  = w_ready;
        if (w_ready)        w_next = S_DECODE;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMMSH;
        if (bus.opcode == OPW'(OP_LW) || bus.opcode == OPW'(OP_SW))         w_next = S_MEMADR;
        else if (bus.opcode == OPW'(OP_RTYPE))                               w_next = S_EXEC;
        else if (bus.opcode == OPW'(OP_BEQ))                                 w_next = S_BRANCH;
        else if (bus.opcode == OPW'(OP_J))                                   w_next = S_JUMP;
        else if (bus.opcode == OPW'(OP_ADDI) || bus.opcode == OPW'(OP_ORI)) w_next = S_IMMEX;
        else begin
          w_illegal_op = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (r_op == OPW'(OP_LW)) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        if (w_ready)        w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        if (w_ready) begin
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_FETCH;
        end
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_B;
        w_alu_op    = ALUOPW'(ALU_FUNCT);
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst    = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALUOPW'(ALU_SUB);
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCSRC_ALUOUT;
        w_instr_done    = 1'b1;
        w_next          = S_FETCH;
      end
      S_IMMEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = (r_op == OPW'(OP_ORI)) ? ALUOPW'(ALU_OR) : ALUOPW'(ALU_ADD);
        w_next      = S_IMMWB;
      end
      S_IMMWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = PCSRC_JUMP;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset gates every output combinationally so an in-flight write dies at once
  assign bus.pc_write      = !reset && w_pc_write;
  assign bus.pc_write_cond = !reset && w_pc_write_cond;
  assign bus.i_or_d        = !reset && w_i_or_d;
  assign bus.mem_read      = !reset && w_mem_read;
  assign bus.mem_write     = !reset && w_mem_write;
  assign bus.ir_write      = !reset && w_ir_write;
  assign bus.mem_to_reg    = !reset && w_mem_to_reg;
  assign bus.reg_dst       = !reset && w_reg_dst;
  assign bus.reg_write     = !reset && w_reg_write;
  assign bus.alu_src_a     = !reset && w_alu_src_a;
  assign bus.alu_src_b     = reset ? '0 : w_alu_src_b;
  assign bus.alu_op        = reset ? '0 : w_alu_op;
  assign bus.pc_source     = reset ? '0 : w_pc_source;
  assign bus.instr_done    = !reset && w_instr_done;
  assign bus.illegal_op    = !reset && w_illegal_op;
  assign bus.mem_timeout   = !reset && w_timeout;
  assign bus.state         = reset ? '0 : r_state;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: an instruction-level model expands each instruction into
// its expected per-cycle state and strobe trace, which drives and checks the DUT.
module tb_multicycle_control;
  localparam int TO = 15;
  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4,
                 ST_MEMWR = 5, ST_EXEC = 6, ST_ALUWB = 7, ST_BRANCH = 8, ST_IMMEX = 9,
                 ST_IMMWB = 10, ST_JUMP = 11;
  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         JMP = 6'b000010, ADDI = 6'b001000, ORI = 6'b001101;

  typedef logic [18:0] vec_t;
  localparam vec_t M_MRD  = vec_t'(1) << 18;
  localparam vec_t M_MWR  = vec_t'(1) << 17;
  localparam vec_t M_IRW  = vec_t'(1) << 16;
  localparam vec_t M_PCW  = vec_t'(1) << 15;
  localparam vec_t M_PWC  = vec_t'(1) << 14;
  localparam vec_t M_IOD  = vec_t'(1) << 13;
  localparam vec_t M_M2R  = vec_t'(1) << 12;
  localparam vec_t M_RD   = vec_t'(1) << 11;
  localparam vec_t M_RW   = vec_t'(1) << 10;
  localparam vec_t M_ASA  = vec_t'(1) << 9;
  localparam vec_t M_DONE = vec_t'(1) << 2;
  localparam vec_t M_ILL  = vec_t'(1) << 1;
  localparam vec_t M_TO   = vec_t'(1);

  function automatic vec_t asb(input int v);  return vec_t'(v) << 7; endfunction
  function automatic vec_t aop(input int v);  return vec_t'(v) << 5; endfunction
  function automatic vec_t psrc(input int v); return vec_t'(v) << 3; endfunction

  typedef struct {
    int         st;
    logic       rdy;
    logic [5:0] opc;
    vec_t       exp;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_cyc    = 0;
  cyc_t q[$];

  multicycle_control_if #(.OPW(6), .ALUOPW(2)) bus ();

  multicycle_control #(
    .OPW(6), .ALUOPW(2), .MEM_WAIT_EN(1), .TIMEOUT(TO), .CNTW(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic vec_t obs();
    return {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_write_cond,
            bus.i_or_d, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op,
            bus.mem_timeout};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {RTYPE, LW, SW, BEQ, JMP, ADDI, ORI};
  endfunction

  task automatic push(input int st, input logic rdy, input logic [5:0] opc, input vec_t exp);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.opc = opc; c.exp = exp;
    q.push_back(c);
  endtask

  // A wait of TO or more not-ready cycles aborts on the TO-th one
  task automatic push_wait(input int st, input int w, input vec_t base, input vec_t done,
                           output bit aborted);
    aborted = 1'b0;
    if (w >= TO) begin
      for (int i = 0; i < TO; i++)
        push(st, 1'b0, 6'($urandom), base | ((i == TO - 1) ? M_TO : '0));
      aborted = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(st, 1'b0, 6'($urandom), base);
      push(st, 1'b1, 6'($urandom), base | done);
    end
  endtask

  task automatic gen(input logic [5:0] op, input int wf, input int wm);
    bit ab;
    push_wait(ST_FETCH, wf, M_MRD | asb(1) | aop(0), M_IRW | M_PCW, ab);
    if (ab) return;
    push(ST_DECODE, 1'($urandom), op, asb(3) | (is_legal(op) ? '0 : M_ILL));
    case (op)
      LW, SW: begin
        push(ST_MEMADR, 1'($urandom), 6'($urandom), M_ASA | asb(2) | aop(0));
        if (op == LW) begin
          push_wait(ST_MEMRD, wm, M_MRD | M_IOD, '0, ab);
          if (!ab) push(ST_MEMWB, 1'($urandom), 6'($urandom), M_RW | M_M2R | M_DONE);
        end else begin
          push_wait(ST_MEMWR, wm, M_MWR | M_IOD, M_DONE, ab);
        end
      end
      RTYPE: begin
        push(ST_EXEC, 1'($urandom), 6'($urandom), M_ASA | asb(0) | aop(2));
        push(ST_ALUWB, 1'($urandom), 6'($urandom), M_RD | M_RW | M_DONE);
      end
      BEQ: push(ST_BRANCH, 1'($urandom), 6'($urandom), M_ASA | aop(1) | M_PWC | psrc(1) | M_DONE);
      JMP: push(ST_JUMP, 1'($urandom), 6'($urandom), M_PCW | psrc(2) | M_DONE);
      ADDI, ORI: begin
        push(ST_IMMEX, 1'($urandom), 6'($urandom), M_ASA | asb(2) | aop(op == ORI ? 3 : 0));
        push(ST_IMMWB, 1'($urandom), 6'($urandom), M_RW | M_DONE);
      end
      default: ;
    endcase
  endtask

  // Entered just after a rising edge; returns just after a rising edge
  task automatic run_trace(input int limit);
    for (int i = 0; i < q.size(); i++) begin
      if (limit >= 0 && i >= limit) break;
      bus.opcode    = q[i].opc;
      bus.mem_ready = q[i].rdy;
      @(negedge clk);
      chk($sformatf("state c%0d", n_cyc), 32'(bus.state), 32'(q[i].st));
      chk($sformatf("outs c%0d st%0d", n_cyc, q[i].st), 32'(obs()), 32'(q[i].exp));
      n_cyc++;
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 10) return r % 4;
    if (r < 12) return TO - 1;
    if (r < 13) return TO;
    if (r < 14) return TO + 5;
    return 0;
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{RTYPE, LW, SW, BEQ, JMP, ADDI, ORI};
    if ($urandom_range(0, 7) != 0) return ops[$urandom_range(0, 6)];
    do op = 6'($urandom); while (is_legal(op));
    return op;
  endfunction

  initial begin
    reset         = 1'b1;
    bus.opcode    = 6'b111111;
    bus.mem_ready = 1'b1;
    #3;
    chk("reset state", 32'(bus.state), 32'd0);
    chk("reset outs", 32'(obs()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    gen(RTYPE, 0, 0);    run_trace(-1);
    gen(LW, 0, 3);       run_trace(-1);
    gen(BEQ, 0, 0);      run_trace(-1);
    gen(JMP, 0, 0);      run_trace(-1);
    gen(ORI, 0, 0);      run_trace(-1);
    gen(ADDI, 1, 0);     run_trace(-1);
    gen(RTYPE, TO, 0);   run_trace(-1);
    gen(RTYPE, TO - 1, 0); run_trace(-1);
    gen(SW, 0, TO - 1);  run_trace(-1);
    gen(LW, 2, TO + 3);  run_trace(-1);
    gen(6'b111111, 0, 0); run_trace(-1);

    // Reset while a store is waiting in MEMWR
    gen(SW, 0, 5);
    run_trace(4);
    bus.mem_ready = 1'b0;
    #1;
    chk("memwr before reset", 32'(bus.mem_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst memwr mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst memwr state", 32'(bus.state), 32'd0);
    chk("rst memwr outs", 32'(obs()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int n = 0; n < 150; n++) begin
      gen(rand_op(), rand_wait(), rand_wait());
      run_trace(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle MIPS control FSM and the successor to the single-cycle combinational decoder. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives per-state datapath strobes and supports a variable-latency memory through a ready handshake with a timeout watchdog. It sits between the instruction register (opcode field) and the shared-memory multi-cycle datapath.

Parameters:
OPW, 6, opcode field width
ALUOPW, 2, ALU-op bus width to the ALU decoder
MEM_WAIT_EN, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready treated as 1
TIMEOUT, 15, wait-cycle limit before abort; 0 disables the watchdog
CNTW, 4, watchdog counter width; must satisfy 2^CNTW > TIMEOUT

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
opcode  in  OPW  instruction[31:26] from the instruction register
mem_ready  in  1  memory has completed the current read or write
pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write  out  1 each  datapath strobes
mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath selects and strobes
alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=imm<<2
alu_op  out  ALUOPW  00=add, 01=sub, 10=use funct, 11=or
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
state  out  4  current state, for debug
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
mem_timeout  out  1  one-cycle pulse when a memory wait is aborted

Behaviour:
- Reset: asynchronous; state=FETCH(0), op_q=0, wait counter=0. While reset is high, all outputs are 0.
- State encoding: FETCH0, DECODE1, MEMADR2, MEMRD3, MEMWB4, MEMWR5, EXEC6, ALUWB7, BRANCH8, IMMEX9, IMMWB10, JUMP11.
- Output defaults: any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00.
  - ir_write and pc_write = mem_ready (asserted only in the completing cycle).
  - On ready, go to DECODE.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=00.
  - Latch opcode into op_q.
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 (addi) or 001101 (ori) -> IMMEX.
  - Any other opcode: illegal_op=1 this cycle, go to FETCH, no writes.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: MEMRD if op_q=lw, else MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Waits for ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. instr_done=1, go to FETCH.
- MEMWR:
  - Outputs: mem_write=1, i_or_d=1, held until ready.
  - On ready: instr_done=1, go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_dst=1, reg_write=1. instr_done=1, go to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
  - instr_done=1, go to FETCH.
- JUMP: pc_write=1, pc_source=10. instr_done=1, go to FETCH.
- IMMEX:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - alu_op = 11 if op_q=ori, else 00.
  - Go to IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. instr_done=1, go to FETCH.
- Latency with zero wait: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3 cycles. Each wait cycle adds one.
- Wait states and watchdog:
  - The counter clears on entry to any wait state and increments each cycle with mem_ready=0.
  - If TIMEOUT>0 and the counter reaches TIMEOUT while still not ready:
    - mem_timeout pulses for one cycle and the FSM goes to FETCH.
    - No ir_write, pc_write, reg_write or instr_done occurs.
    - mem_read/mem_write drop in the next cycle.
  - mem_ready arriving in the same cycle the counter hits TIMEOUT counts as success; ready wins.
  - The counter saturates and never wraps.
- Outputs are Moore, decoded from the state; exceptions are the ready-gated strobes and the pulses.
- Reset mid-instruction: outputs drop to 0 immediately and no partial write completes. After release, fetch restarts.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI;
  - ALU-op encodings;
  - alu_src_b and pc_source encodings;
  - the state enum.
- One natural sub-module, mem_wait_watchdog: the counter plus the timeout compare, producing mem_timeout.
- The FSM and output decode stay in multicycle_control.

Test Plan:
- R-type, mem_ready=1: states 0,1,6,7,0. reg_write=1 and reg_dst=1 only in cycle 4; instr_done pulses in cycle 4; alu_op=10 in cycle 3.
- lw with mem_ready low for 3 cycles in MEMRD: total 8 cycles. mem_read and i_or_d held high for 4 cycles; reg_write with mem_to_reg=1 occurs once.
- beq then j: beq gives pc_write_cond=1, pc_source=01, alu_op=01 in cycle 3. j gives pc_write=1, pc_source=10 in cycle 3. Each is 3 cycles.
- ori vs addi: alu_op in IMMEX is 11 for ori and 00 for addi. Opcode is changed after DECODE to confirm op_q is used.
- TIMEOUT=15, mem_ready held 0 in FETCH: mem_timeout pulses at the 15th wait cycle and the FSM re-enters FETCH. ir_write and pc_write are never asserted. A second run with ready on cycle 15 completes normally.
- Opcode 111111: illegal_op pulses in DECODE, the FSM returns to FETCH with no write. A reset asserted in MEMWR forces mem_write=0 asynchronously and state=0.
